axi_line_burst_master: RTL and testbench

Converts single-cycle cache-line read/write requests from the core-side memory port into AXI4 INCR bursts on the AXI slave port of the DDR3 controller. It sits directly upstream of the DDR3 controller's AXI interface, in place of any hand-built AXI driver. It holds one line transaction in flight, issues AW/W or AR, gathers R beats into a line, and returns a single-cycle line response.

---
 rtl/axi_line_burst_master_pkg.sv | 19 +
 rtl/axi_line_burst_master_if.sv | 62 ++++++
 rtl/axi_line_burst_master.sv | 140 ++++++++++++++
 tb/tb_axi_line_burst_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_line_burst_master_pkg.sv
// Shared memory-interface definitions: AXI burst/response encodings and the
// line-burst master state enum.
package axi_line_burst_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/axi_line_burst_master_if.sv
// Core-side line request/response port plus the AXI4 master channels toward
// the DDR3 controller. "master" is the burst master's view, "slave" the peer's.
interface axi_line_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int BEATS  = 8
);
  logic                      req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]         req_addr;
  logic [ID_W-1:0]           req_id;
  logic [BEATS*DATA_W-1:0]   req_wdata;

  logic                      rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [ID_W-1:0]           rsp_id;
  logic [BEATS*DATA_W-1:0]   rsp_rdata;

  logic                      awvalid, awready;
  logic [ID_W-1:0]           awid;
  logic [ADDR_W-1:0]         awaddr;
  logic [7:0]                awlen;
  logic [1:0]                awburst;

  logic                      wvalid, wready, wlast;
  logic [DATA_W-1:0]         wdata;
  logic [DATA_W/8-1:0]       wstrb;

  logic                      bvalid, bready;
  logic [ID_W-1:0]           bid;
  logic [1:0]                bresp;

  logic                      arvalid, arready;
  logic [ID_W-1:0]           arid;
  logic [ADDR_W-1:0]         araddr;
  logic [7:0]                arlen;
  logic [1:0]                arburst;

  logic                      rvalid, rready, rlast;
  logic [ID_W-1:0]           rid;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;

  modport master (
    input  req_valid, req_write, req_addr, req_id, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_id, rsp_err, rsp_rdata,
    output awvalid, awid, awaddr, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arburst, input arready,
    input  rvalid, rid, rdata, rlast, rresp, output rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_id, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_id, rsp_err, rsp_rdata,
    input  awvalid, awid, awaddr, awlen, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arburst, output arready,
    output rvalid, rid, rdata, rlast, rresp, input rready
  );
endinterface

// File: rtl/axi_line_burst_master.sv
// Turns one cache-line read/write request into an AXI4 INCR burst and returns a
// single line response; one transaction in flight at a time.
module axi_line_burst_master
  import axi_line_burst_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int BEATS  = 8
) (
  input logic                     i_clk,
  input logic                     i_rst,
  axi_line_burst_master_if.master bus
);
  localparam int LINE_W = BEATS * DATA_W;
  localparam int LSB    = $clog2(LINE_W / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t            r_state, w_next_state;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic              r_write, r_err, r_aw_done, r_w_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_wdata, r_line;

  logic w_is_last, w_req_hs, w_aw_hs, w_w_hs, w_r_end;

  assign w_is_last = (r_cnt == LAST_BEAT);
  assign w_req_hs  = bus.req_valid && r_req_ready;
  assign w_aw_hs   = bus.awvalid && bus.awready;
  assign w_w_hs    = bus.wvalid && bus.wready;
  assign w_r_end   = bus.rvalid && (bus.rlast || w_is_last);

  // Every output is a register or a decode of state, never of an AXI input.
  assign bus.req_ready = r_req_ready;
  assign bus.arvalid   = (r_state == ST_RD_ADDR);
  assign bus.arid      = r_id;
  assign bus.araddr    = r_addr;
  assign bus.arlen     = 8'(BEATS - 1);
  assign bus.arburst   = AXI_BURST_INCR;
  assign bus.rready    = (r_state == ST_RD_DATA);
  assign bus.awvalid   = (r_state == ST_WR) && !r_aw_done;
  assign bus.awid      = r_id;
  assign bus.awaddr    = r_addr;
  assign bus.awlen     = 8'(BEATS - 1);
  assign bus.awburst   = AXI_BURST_INCR;
  assign bus.wvalid    = (r_state == ST_WR) && !r_w_done;
  assign bus.wdata     = r_wdata[int'(r_cnt) * DATA_W +: DATA_W];
  assign bus.wstrb     = '1;
  assign bus.wlast     = (r_state == ST_WR) && w_is_last;
  assign bus.bready    = (r_state == ST_WR_RESP);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_write = r_write;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_line;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == ST_IDLE);
    end
  end

  always_comb begin
    // NOTE: default first, so no branch leaves the signal unassigned and no
    // latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_req_hs) w_next_state = bus.req_write ? ST_WR : ST_RD_ADDR;
      ST_RD_ADDR: if (bus.arready) w_next_state = ST_RD_DATA;
      ST_RD_DATA: if (w_r_end) w_next_state = ST_RESP;
      ST_WR:      if ((r_aw_done || w_aw_hs) && (r_w_done || (w_w_hs && w_is_last)))
                    w_next_state = ST_WR_RESP;
      ST_WR_RESP: if (bus.bvalid) w_next_state = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: the line buffers drive rsp_rdata/wdata directly, so they are reset
  // to keep those outputs at zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr    <= '0;
      r_id      <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_line    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req_hs) begin
          r_addr    <= {bus.req_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
          r_id      <= bus.req_id;
          r_write   <= bus.req_write;
          r_wdata   <= bus.req_wdata;
          r_line    <= '0;
          r_err     <= 1'b0;
          r_cnt     <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        ST_RD_DATA: if (bus.rvalid) begin
          r_line[int'(r_cnt) * DATA_W +: DATA_W] <= bus.rdata;
          r_cnt <= r_cnt + 1'b1;
          r_err <= r_err | (bus.rresp != AXI_RESP_OKAY) | (bus.rid != r_id)
                         | (bus.rlast != w_is_last);
        end
        ST_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_is_last) r_w_done <= 1'b1;
          end
        end
        ST_WR_RESP: if (bus.bvalid)
          r_err <= r_err | (bus.bresp != AXI_RESP_OKAY) | (bus.bid != r_id);
        ST_RESP: if (bus.rsp_ready) begin
          r_err     <= 1'b0;
          r_cnt     <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_burst_master.sv
// Self-checking bench for axi_line_burst_master: scoreboard of expected line
// responses plus inline AXI slave behaviour per scenario.
module tb_axi_line_burst_master;
  import axi_line_burst_master_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int BEATS  = 8;
  localparam int LINE_W = BEATS * DATA_W;

  typedef struct packed {
    logic              write;
    logic [ID_W-1:0]   id;
    logic              err;
    logic [LINE_W-1:0] rdata;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  axi_line_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BEATS(BEATS)) bus ();

  axi_line_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BEATS(BEATS)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [LINE_W-1:0] make_line(input logic [DATA_W-1:0] base, input int n);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int k = 0; k < n; k++) l[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    return l;
  endfunction

  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [ID_W-1:0] id, input logic [LINE_W-1:0] wd);
    int t = 0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_id = id; bus.req_wdata = wd;
    while (!bus.req_ready && t < 50) begin @(negedge i_clk); t++; end
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL req_accept: req_ready=%b required 1", bus.req_ready);
    else n_pass++;
    @(negedge i_clk);
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_id = '0; bus.req_wdata = '0;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL req_busy: req_ready=%b required 0", bus.req_ready);
    else n_pass++;
  endtask

  task automatic rd_slave(input logic [ADDR_W-1:0] exp_addr, input logic [ID_W-1:0] exp_id,
                          input logic [ID_W-1:0] drv_id, input logic [DATA_W-1:0] base,
                          input int n_beats, input bit give_rlast, input int err_beat,
                          input logic [1:0] err_resp, input int ar_wait);
    int t = 0;
    while (!bus.arvalid && t < ar_wait) begin @(negedge i_clk); t++; end
    n_checks++;
    if ({bus.arvalid, bus.araddr, bus.arlen, bus.arid, bus.arburst} !==
        {1'b1, exp_addr, 8'(BEATS-1), exp_id, AXI_BURST_INCR})
      $display("FAIL ar_channel: valid=%b addr=%h len=%0d id=%0d burst=%b required 1 %h %0d %0d 01",
               bus.arvalid, bus.araddr, bus.arlen, bus.arid, bus.arburst, exp_addr, BEATS-1, exp_id);
    else n_pass++;
    bus.arready = 1'b1;
    @(negedge i_clk);
    bus.arready = 1'b0;
    n_checks++;
    if ({bus.arvalid, bus.rready} !== 2'b01)
      $display("FAIL ar_done: arvalid=%b rready=%b required 0 1", bus.arvalid, bus.rready);
    else n_pass++;
    for (int k = 0; k < n_beats; k++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = base + DATA_W'(k);
      bus.rid    = drv_id;
      bus.rresp  = (k == err_beat) ? err_resp : AXI_RESP_OKAY;
      bus.rlast  = give_rlast && (k == n_beats - 1);
      @(negedge i_clk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = AXI_RESP_OKAY; bus.rid = '0;
  endtask

  task automatic wr_slave(input logic [ADDR_W-1:0] exp_addr, input logic [ID_W-1:0] exp_id,
                          input logic [LINE_W-1:0] line, input int aw_delay, input bit toggle,
                          input logic [ID_W-1:0] drv_bid, input logic [1:0] drv_bresp,
                          output int iters);
    int t = 0;
    int beats = 0;
    bit aw_seen = 0;
    bit dropped = 0;
    while ((beats < BEATS || !aw_seen) && t < 200) begin
      bus.awready = (t >= aw_delay);
      bus.wready  = toggle ? t[0] : 1'b1;
      if (!aw_seen) begin
        if (!bus.awvalid) dropped = 1;
        else if (bus.awready) begin
          aw_seen = 1;
          n_checks++;
          if ({bus.awaddr, bus.awlen, bus.awid, bus.awburst} !==
              {exp_addr, 8'(BEATS-1), exp_id, AXI_BURST_INCR})
            $display("FAIL aw_channel: addr=%h len=%0d id=%0d burst=%b required %h %0d %0d 01",
                     bus.awaddr, bus.awlen, bus.awid, bus.awburst, exp_addr, BEATS-1, exp_id);
          else n_pass++;
        end
      end
      if (beats < BEATS) begin
        if (!bus.wvalid) dropped = 1;
        else if (bus.wready) begin
          n_checks++;
          if ({bus.wdata, bus.wlast, bus.wstrb} !==
              {line[beats*DATA_W +: DATA_W], beats == BEATS-1, {(DATA_W/8){1'b1}}})
            $display("FAIL w_beat%0d: data=%h last=%b strb=%h required %h %b f",
                     beats, bus.wdata, bus.wlast, bus.wstrb, line[beats*DATA_W +: DATA_W], beats == BEATS-1);
          else n_pass++;
          beats++;
        end
      end
      @(negedge i_clk);
      t++;
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    iters = t;
    n_checks++;
    if ({aw_seen, dropped, beats} !== {1'b1, 1'b0, BEATS})
      $display("FAIL w_complete: aw_seen=%b valid_dropped=%b beats=%0d required 1 0 %0d", aw_seen, dropped, beats, BEATS);
    else n_pass++;
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001)
      $display("FAIL w_idle: awvalid=%b wvalid=%b bready=%b required 0 0 1", bus.awvalid, bus.wvalid, bus.bready);
    else n_pass++;
    bus.bvalid = 1'b1; bus.bid = drv_bid; bus.bresp = drv_bresp;
    t = 0;
    while (!bus.bready && t < 50) begin @(negedge i_clk); t++; end
    @(negedge i_clk);
    bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = AXI_RESP_OKAY;
  endtask

  task automatic collect_rsp(input int max_wait, input int hold);
    exp_t e;
    int t = 0;
    bit unstable = 0;
    logic [LINE_W+ID_W+1:0] snap;
    while (!bus.rsp_valid && t < max_wait) begin @(negedge i_clk); t++; end
    n_checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL rsp_valid: got %b after %0d cycles required 1", bus.rsp_valid, t);
    else n_pass++;
    e = sb.pop_front();
    snap = {bus.rsp_write, bus.rsp_id, bus.rsp_err, bus.rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      if (!bus.rsp_valid || snap !== {bus.rsp_write, bus.rsp_id, bus.rsp_err, bus.rsp_rdata} ||
          bus.req_ready || bus.arvalid || bus.awvalid || bus.wvalid) unstable = 1;
    end
    if (hold > 0) begin
      n_checks++;
      if (unstable) $display("FAIL rsp_hold: response or idle outputs changed under backpressure, required stable");
      else n_pass++;
    end
    n_checks++;
    if ({bus.rsp_write, bus.rsp_id} !== {e.write, e.id})
      $display("FAIL rsp_type_id: write=%b id=%0d required %b %0d", bus.rsp_write, bus.rsp_id, e.write, e.id);
    else n_pass++;
    n_checks++;
    if (bus.rsp_err !== e.err) $display("FAIL rsp_err: got %b required %b", bus.rsp_err, e.err);
    else n_pass++;
    n_checks++;
    if (bus.rsp_rdata !== e.rdata) $display("FAIL rsp_rdata: got %h required %h", bus.rsp_rdata, e.rdata);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL rsp_busy: req_ready=%b required 0", bus.req_ready);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(negedge i_clk);
    bus.rsp_ready = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL rsp_release: rsp_valid=%b req_ready=%b required 0 1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({bus.req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.rsp_valid, bus.wlast} !== 8'h00)
      $display("FAIL reset_handshakes: got %b required 00000000",
               {bus.req_ready, bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.rsp_valid, bus.wlast});
    else n_pass++;
    n_checks++;
    if ({bus.arlen, bus.awlen, bus.arburst, bus.awburst, bus.wstrb} !== {8'd7, 8'd7, 2'b01, 2'b01, 4'hf})
      $display("FAIL reset_consts: arlen=%0d awlen=%0d arburst=%b awburst=%b wstrb=%h required 7 7 01 01 f",
               bus.arlen, bus.awlen, bus.arburst, bus.awburst, bus.wstrb);
    else n_pass++;
    n_checks++;
    if ({bus.araddr, bus.awaddr, bus.wdata, bus.arid, bus.awid, bus.rsp_id, bus.rsp_err, bus.rsp_write} !== '0 ||
        bus.rsp_rdata !== '0)
      $display("FAIL reset_payload: araddr=%h awaddr=%h wdata=%h rsp_rdata=%h required all 0",
               bus.araddr, bus.awaddr, bus.wdata, bus.rsp_rdata);
    else n_pass++;
    i_rst = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL reset_release: req_ready=%b required 0", bus.req_ready);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_read();
    sb.push_back('{write: 1'b0, id: 4'd3, err: 1'b0, rdata: make_line('0, 8)});
    send_req(1'b0, 32'h1000_0014, 4'd3, '0);
    rd_slave(32'h1000_0000, 4'd3, 4'd3, '0, 8, 1'b1, -1, AXI_RESP_OKAY, 0);
    collect_rsp(0, 0);
  endtask

  task automatic test_write_stall();
    logic [LINE_W-1:0] line;
    int iters;
    for (int k = 0; k < BEATS; k++) line[k*DATA_W +: DATA_W] = $urandom();
    sb.push_back('{write: 1'b1, id: 4'd5, err: 1'b0, rdata: '0});
    send_req(1'b1, 32'h2000_0047, 4'd5, line);
    wr_slave(32'h2000_0040, 4'd5, line, 5, 1'b1, 4'd5, AXI_RESP_OKAY, iters);
    collect_rsp(0, 0);
  endtask

  task automatic test_errors();
    logic [LINE_W-1:0] line;
    int iters;
    sb.push_back('{write: 1'b0, id: 4'd7, err: 1'b1, rdata: make_line(32'hA000_0000, 8)});
    send_req(1'b0, 32'h0000_1234, 4'd7, '0);
    rd_slave(32'h0000_1220, 4'd7, 4'd7, 32'hA000_0000, 8, 1'b1, 4, AXI_RESP_SLVERR, 0);
    collect_rsp(0, 0);
    line = make_line(32'h5A5A_0000, 8);
    sb.push_back('{write: 1'b1, id: 4'd9, err: 1'b1, rdata: '0});
    send_req(1'b1, 32'h3000_0000, 4'd9, line);
    wr_slave(32'h3000_0000, 4'd9, line, 0, 1'b0, 4'd9, AXI_RESP_DECERR, iters);
    n_checks++;
    if (iters !== BEATS) $display("FAIL write_latency: last W after %0d cycles required %0d", iters, BEATS);
    else n_pass++;
    collect_rsp(0, 0);
  endtask

  task automatic test_protocol_faults();
    sb.push_back('{write: 1'b0, id: 4'd3, err: 1'b1, rdata: make_line(32'hB000_0000, 6)});
    send_req(1'b0, 32'h4000_0100, 4'd3, '0);
    rd_slave(32'h4000_0100, 4'd3, 4'd3, 32'hB000_0000, 6, 1'b1, -1, AXI_RESP_OKAY, 0);
    collect_rsp(0, 0);
    sb.push_back('{write: 1'b0, id: 4'd3, err: 1'b1, rdata: make_line(32'hC000_0000, 8)});
    send_req(1'b0, 32'h4000_0200, 4'd3, '0);
    rd_slave(32'h4000_0200, 4'd3, 4'd2, 32'hC000_0000, 8, 1'b1, -1, AXI_RESP_OKAY, 0);
    collect_rsp(0, 0);
  endtask

  task automatic test_backpressure();
    sb.push_back('{write: 1'b0, id: 4'd4, err: 1'b0, rdata: make_line(32'h0BAD_F000, 8)});
    send_req(1'b0, 32'h6000_0020, 4'd4, '0);
    rd_slave(32'h6000_0020, 4'd4, 4'd4, 32'h0BAD_F000, 8, 1'b1, -1, AXI_RESP_OKAY, 0);
    collect_rsp(0, 10);
  endtask

  task automatic test_reset_mid_op();
    send_req(1'b0, 32'h5000_0000, 4'd6, '0);
    rd_slave(32'h5000_0000, 4'd6, 4'd6, 32'hDEAD_0000, 3, 1'b0, -1, AXI_RESP_OKAY, 0);
    n_checks++;
    if (bus.rready !== 1'b1) $display("FAIL mid_rd_data: rready=%b required 1", bus.rready);
    else n_pass++;
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_0003; bus.rid = 4'd6;
    #2 i_rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.rsp_valid, bus.req_ready} !== 7'b0)
      $display("FAIL async_reset: valids/readys=%b required 0000000",
               {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.rsp_valid, bus.req_ready});
    else n_pass++;
    bus.rvalid = 1'b0; bus.rdata = '0; bus.rid = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL post_reset_ready: req_ready=%b required 1", bus.req_ready);
    else n_pass++;
    sb.push_back('{write: 1'b0, id: 4'd6, err: 1'b0, rdata: make_line(32'hE000_0000, 8)});
    send_req(1'b0, 32'h5000_0000, 4'd6, '0);
    rd_slave(32'h5000_0000, 4'd6, 4'd6, 32'hE000_0000, 8, 1'b1, -1, AXI_RESP_OKAY, 0);
    collect_rsp(0, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_id = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = AXI_RESP_OKAY;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rlast = 1'b0; bus.rresp = AXI_RESP_OKAY;
    test_reset();
    test_read();
    test_write_stall();
    test_errors();
    test_protocol_faults();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
